// File: rtl/wb_queue.sv
// Purpose : in-order write-back queue between the mem/alu result producers and the
//           register-file write port, with decode-stage hazard lookup / forwarding.
// Latency : a result accepted at edge N into an empty queue is on the write port in cycle N+1.
// Backpressure: ready_out drops when fewer than 2 entries are free; results offered then
//           are dropped and latch the sticky err_out.
//
// Ports:
//   clk_in, rst_in                       clock, synchronous active-high reset
//   memE/Idx/Data_in, aluE/Idx/Data_in   producer results (mem is older, enqueued first)
//   ready_out, err_out                   >=2 free entries / sticky overflow flag
//   writeE/Idx/Data_out                  register-file write port driven from the head entry
//   reg1/2Idx_in                         decode read indices
//   reg1/2Busy_out, reg1/2Hit_out,
//   reg1/2FwdData_out                    hazard status / forwarded value
// Build option: define WBQ_FORWARD_EN to forward the youngest matching value instead of
//   reporting busy.
module wb_queue #(
   parameter int DEPTH = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        memE_in,
   input  logic [4:0]  memIdx_in,
   input  logic [31:0] memData_in,
   input  logic        aluE_in,
   input  logic [4:0]  aluIdx_in,
   input  logic [31:0] aluData_in,
   output logic        ready_out,
   output logic        err_out,
   output logic        writeE_out,
   output logic [4:0]  writeIdx_out,
   output logic [31:0] writeData_out,
   input  logic [4:0]  reg1Idx_in,
   input  logic [4:0]  reg2Idx_in,
   output logic        reg1Busy_out,
   output logic        reg2Busy_out,
   output logic        reg1Hit_out,
   output logic [31:0] reg1FwdData_out,
   output logic        reg2Hit_out,
   output logic [31:0] reg2FwdData_out
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0] vld_q, vld_d;
   logic [4:0]       idx_q  [DEPTH];
   logic [4:0]       idx_d  [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [31:0]      data_d [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             err_q, err_d;

   logic             ready;
   logic             mem_ok, alu_ok;
   logic             head_we;
   logic             m1, m2;

   // Credit is based on registered occupancy only, so a full-rate drain
   // never lets a two-result burst overflow.
   assign ready = (count_q <= CW'(DEPTH - 2));

   // Reset gates the write port so queued entries are never written while being flushed.
   assign head_we       = vld_q[rd_ptr_q] & ~rst_in;
   assign writeE_out    = head_we;
   assign writeIdx_out  = head_we ? idx_q[rd_ptr_q]  : 5'd0;
   assign writeData_out = head_we ? data_q[rd_ptr_q] : 32'd0;
   assign ready_out     = ready;
   assign err_out       = err_q;

   assign mem_ok = ready & memE_in & (memIdx_in != 5'd0);
   assign alu_ok = ready & aluE_in & (aluIdx_in != 5'd0);

   always_comb begin
      vld_d    = vld_q;
      idx_d    = idx_q;
      data_d   = data_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      err_d    = err_q | (~ready & (memE_in | aluE_in));

      if (head_we) begin
         vld_d[rd_ptr_q] = 1'b0;
         rd_ptr_d        = rd_ptr_q + 1'b1;
      end
      // Enqueue targets are always free slots (>=2 free), so they never
      // collide with the head being retired this edge.
      if (mem_ok) begin
         vld_d[wr_ptr_d]  = 1'b1;
         idx_d[wr_ptr_d]  = memIdx_in;
         data_d[wr_ptr_d] = memData_in;
         wr_ptr_d         = wr_ptr_d + 1'b1;
      end
      if (alu_ok) begin
         vld_d[wr_ptr_d]  = 1'b1;
         idx_d[wr_ptr_d]  = aluIdx_in;
         data_d[wr_ptr_d] = aluData_in;
         wr_ptr_d         = wr_ptr_d + 1'b1;
      end
      count_d = count_q + CW'(mem_ok) + CW'(alu_ok) - CW'(head_we);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         vld_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         vld_q    <= vld_d;
         idx_q    <= idx_d;
         data_q   <= data_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         err_q    <= err_d;
      end
   end

   // Hazard lookup: walk entries oldest to youngest so the last match wins,
   // giving the youngest value. The head still matches while it is being
   // written; the register file's write-first bypass covers that cycle.
`ifdef WBQ_FORWARD_EN
   logic [31:0] d1, d2;
`endif
   always_comb begin
      m1 = 1'b0;
      m2 = 1'b0;
`ifdef WBQ_FORWARD_EN
      d1 = 32'd0;
      d2 = 32'd0;
`endif
      for (int k = 0; k < DEPTH; k++) begin
         if (vld_q[rd_ptr_q + PW'(k)] && (reg1Idx_in != 5'd0) &&
             (idx_q[rd_ptr_q + PW'(k)] == reg1Idx_in)) begin
            m1 = 1'b1;
`ifdef WBQ_FORWARD_EN
            d1 = data_q[rd_ptr_q + PW'(k)];
`endif
         end
         if (vld_q[rd_ptr_q + PW'(k)] && (reg2Idx_in != 5'd0) &&
             (idx_q[rd_ptr_q + PW'(k)] == reg2Idx_in)) begin
            m2 = 1'b1;
`ifdef WBQ_FORWARD_EN
            d2 = data_q[rd_ptr_q + PW'(k)];
`endif
         end
      end
   end

`ifdef WBQ_FORWARD_EN
   assign reg1Hit_out     = m1;
   assign reg1FwdData_out = d1;
   assign reg2Hit_out     = m2;
   assign reg2FwdData_out = d2;
   assign reg1Busy_out    = 1'b0;
   assign reg2Busy_out    = 1'b0;
`else
   assign reg1Hit_out     = 1'b0;
   assign reg1FwdData_out = 32'd0;
   assign reg2Hit_out     = 1'b0;
   assign reg2FwdData_out = 32'd0;
   assign reg1Busy_out    = m1;
   assign reg2Busy_out    = m2;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Purpose : directed self-checking bench for wb_queue (DEPTH = 4).
// Latency : inputs change 1 time unit after a rising edge; outputs sampled there too.
// Backpressure: overflow is provoked deliberately to check ready_out/err_out.
module tb_wb_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        memE = 1'b0, aluE = 1'b0;
   logic [4:0]  memIdx = '0, aluIdx = '0;
   logic [31:0] memData = '0, aluData = '0;
   logic        ready, err, wE;
   logic [4:0]  wIdx;
   logic [31:0] wData;
   logic [4:0]  r1Idx = '0, r2Idx = '0;
   logic        r1Busy, r2Busy, r1Hit, r2Hit;
   logic [31:0] r1Fwd, r2Fwd;

   int total = 0;
   int bad   = 0;

`ifdef WBQ_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   always #5 clk = ~clk;

   wb_queue #(.DEPTH(4)) dut (
      .clk_in(clk), .rst_in(rst),
      .memE_in(memE), .memIdx_in(memIdx), .memData_in(memData),
      .aluE_in(aluE), .aluIdx_in(aluIdx), .aluData_in(aluData),
      .ready_out(ready), .err_out(err),
      .writeE_out(wE), .writeIdx_out(wIdx), .writeData_out(wData),
      .reg1Idx_in(r1Idx), .reg2Idx_in(r2Idx),
      .reg1Busy_out(r1Busy), .reg2Busy_out(r2Busy),
      .reg1Hit_out(r1Hit), .reg1FwdData_out(r1Fwd),
      .reg2Hit_out(r2Hit), .reg2FwdData_out(r2Fwd)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      memE = 1'b0; aluE = 1'b0;
      memIdx = '0; aluIdx = '0; memData = '0; aluData = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; idle(); r1Idx = 5'd5; r2Idx = 5'd6;
      cyc(); cyc();
      rst = 1'b0;
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", ready); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", err); end
      total++; if ({wE, wIdx, wData} !== 38'd0) begin bad++; $display("FAIL reset_write got=%0b/%0d/%h exp=0/0/0", wE, wIdx, wData); end
      total++; if ({r1Busy, r2Busy, r1Hit, r2Hit} !== 4'b0) begin bad++; $display("FAIL reset_hazard got=%b exp=0000", {r1Busy, r2Busy, r1Hit, r2Hit}); end
      total++; if ({r1Fwd, r2Fwd} !== 64'd0) begin bad++; $display("FAIL reset_fwd got=%h/%h exp=0/0", r1Fwd, r2Fwd); end
   endtask

   task automatic test_basic();
      memE = 1'b1; memIdx = 5'd5; memData = 32'h11;
      aluE = 1'b1; aluIdx = 5'd6; aluData = 32'h22;
      r1Idx = 5'd6; r2Idx = 5'd5;
      cyc(); idle();
      total++; if ({wE, wIdx, wData} !== {1'b1, 5'd5, 32'h11}) begin bad++; $display("FAIL basic_c1 got=%0b/%0d/%h exp=1/5/11", wE, wIdx, wData); end
      total++; if ({r1Busy, r1Hit, r1Fwd} !== {~FWD, FWD, (FWD ? 32'h22 : 32'h0)}) begin bad++; $display("FAIL basic_hz_x6 got=%0b/%0b/%h", r1Busy, r1Hit, r1Fwd); end
      total++; if ({r2Busy, r2Hit, r2Fwd} !== {~FWD, FWD, (FWD ? 32'h11 : 32'h0)}) begin bad++; $display("FAIL basic_hz_head_x5 got=%0b/%0b/%h", r2Busy, r2Hit, r2Fwd); end
      cyc();
      total++; if ({wE, wIdx, wData} !== {1'b1, 5'd6, 32'h22}) begin bad++; $display("FAIL basic_c2 got=%0b/%0d/%h exp=1/6/22", wE, wIdx, wData); end
      total++; if ({r2Busy, r2Hit} !== 2'b00) begin bad++; $display("FAIL basic_x5_retired got=%0b/%0b exp=0/0", r2Busy, r2Hit); end
      cyc();
      total++; if (wE !== 1'b0) begin bad++; $display("FAIL basic_c3 got=%0b exp=0", wE); end
   endtask

   task automatic test_x0();
      aluE = 1'b1; aluIdx = 5'd0; aluData = 32'hFF;
      memE = 1'b1; memIdx = 5'd0; memData = 32'hEE;
      cyc(); idle();
      total++; if (wE !== 1'b0) begin bad++; $display("FAIL x0_write got=%0b exp=0", wE); end
      cyc();
      total++; if ({wE, ready} !== 2'b01) begin bad++; $display("FAIL x0_empty got=%0b/%0b exp=0/1", wE, ready); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL x0_err got=%0b exp=0", err); end
   endtask

   task automatic test_forward();
      memE = 1'b1; memIdx = 5'd7; memData = 32'h1;
      aluE = 1'b1; aluIdx = 5'd7; aluData = 32'h2;
      r1Idx = 5'd7; r2Idx = 5'd8;
      cyc(); idle();
      total++; if ({r1Busy, r1Hit, r1Fwd} !== {~FWD, FWD, (FWD ? 32'h2 : 32'h0)}) begin bad++; $display("FAIL fwd_youngest got=%0b/%0b/%h", r1Busy, r1Hit, r1Fwd); end
      total++; if ({r2Busy, r2Hit} !== 2'b00) begin bad++; $display("FAIL fwd_nomatch got=%0b/%0b exp=0/0", r2Busy, r2Hit); end
      r2Idx = 5'd0;
      #1;
      total++; if ({r2Busy, r2Hit} !== 2'b00) begin bad++; $display("FAIL fwd_idx0 got=%0b/%0b exp=0/0", r2Busy, r2Hit); end
      cyc();
      total++; if ({wIdx, wData} !== {5'd7, 32'h2}) begin bad++; $display("FAIL fwd_second got=%0d/%h exp=7/2", wIdx, wData); end
      total++; if ({r1Busy, r1Hit, r1Fwd} !== {~FWD, FWD, (FWD ? 32'h2 : 32'h0)}) begin bad++; $display("FAIL fwd_after_pop got=%0b/%0b/%h", r1Busy, r1Hit, r1Fwd); end
      cyc();
      total++; if ({wE, r1Busy, r1Hit} !== 3'b000) begin bad++; $display("FAIL fwd_drained got=%b exp=000", {wE, r1Busy, r1Hit}); end
   endtask

   task automatic test_overflow();
      memE = 1'b1; memIdx = 5'd1; memData = 32'hA;
      aluE = 1'b1; aluIdx = 5'd2; aluData = 32'hB;
      cyc();
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL ovf_ready_cnt2 got=%0b exp=1", ready); end
      memIdx = 5'd3; memData = 32'hC;
      aluIdx = 5'd4; aluData = 32'hD;
      cyc();
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL ovf_ready_cnt3 got=%0b exp=0", ready); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL ovf_err_early got=%0b exp=0", err); end
      aluE = 1'b0; memIdx = 5'd9; memData = 32'h99;
      cyc(); idle();
      total++; if (err !== 1'b1) begin bad++; $display("FAIL ovf_err_set got=%0b exp=1", err); end
      total++; if ({wIdx, wData, ready} !== {5'd3, 32'hC, 1'b1}) begin bad++; $display("FAIL ovf_head got=%0d/%h/%0b exp=3/c/1", wIdx, wData, ready); end
      cyc();
      total++; if ({wE, wIdx, wData} !== {1'b1, 5'd4, 32'hD}) begin bad++; $display("FAIL ovf_last got=%0b/%0d/%h exp=1/4/d", wE, wIdx, wData); end
      cyc();
      total++; if ({wE, err} !== 2'b01) begin bad++; $display("FAIL ovf_err_hold got=%0b/%0b exp=0/1", wE, err); end
   endtask

   task automatic test_reset_mid();
      memE = 1'b1; memIdx = 5'd10; memData = 32'h10;
      aluE = 1'b1; aluIdx = 5'd11; aluData = 32'h11;
      cyc();
      memIdx = 5'd12; aluIdx = 5'd13;
      cyc(); idle();
      r1Idx = 5'd12;
      rst = 1'b1;
      #1;
      total++; if (wE !== 1'b0) begin bad++; $display("FAIL rstmid_nowrite got=%0b exp=0", wE); end
      cyc();
      rst = 1'b0;
      total++; if ({wE, ready, err} !== 3'b010) begin bad++; $display("FAIL rstmid_state got=%b exp=010", {wE, ready, err}); end
      total++; if ({r1Busy, r1Hit} !== 2'b00) begin bad++; $display("FAIL rstmid_hazard got=%0b/%0b exp=0/0", r1Busy, r1Hit); end
      for (int i = 0; i < 4; i++) begin
         cyc();
         total++; if (wE !== 1'b0) begin bad++; $display("FAIL rstmid_ghost%0d got=%0b exp=0", i, wE); end
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 20; k++) begin
         if (k % 2 == 0) begin
            idle(); memE = 1'b1; memIdx = 5'(k + 1); memData = 32'h100 + 32'(k);
         end else begin
            idle(); aluE = 1'b1; aluIdx = 5'(k + 1); aluData = 32'h100 + 32'(k);
         end
         cyc();
         total++; if ({wE, wIdx, wData} !== {1'b1, 5'(k + 1), 32'h100 + 32'(k)}) begin bad++; $display("FAIL b2b_%0d got=%0b/%0d/%h exp=1/%0d/%h", k, wE, wIdx, wData, k + 1, 32'h100 + 32'(k)); end
      end
      idle();
      cyc();
      total++; if ({wE, ready, err} !== 3'b010) begin bad++; $display("FAIL b2b_end got=%b exp=010", {wE, ready, err}); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_x0();
      test_forward();
      test_overflow();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter DEPTH, default 4: queue entries; power of two, at least 2.
REQ-002 clk_in  input  1  single clock; all state updates on rising edge.
REQ-003 rst_in  input  1  reset, synchronous, active-high.
REQ-004 memE_in / memIdx_in / memData_in  input  1/5/32  older result: valid, destination register, value.
REQ-005 aluE_in / aluIdx_in / aluData_in  input  1/5/32  younger result: valid, destination register, value.
REQ-006 ready_out  output  1  high when at least 2 entries are free.
REQ-007 err_out  output  1  sticky flag: a result was offered while ready_out was low.
REQ-008 writeE_out / writeIdx_out / writeData_out  output  1/5/32  register-file write port.
REQ-009 reg1Idx_in, reg2Idx_in  input  5 each  decode-stage read indices for hazard lookup.
REQ-010 reg1Busy_out, reg2Busy_out  output  1 each  a queued write to that index is outstanding.
REQ-011 reg1Hit_out / reg1FwdData_out, reg2Hit_out / reg2FwdData_out  output  1/32 each  forward result; present in every build.

Function
REQ-012 Enqueue: at a rising edge with ready_out high, each asserted producer with Idx != 0 SHALL be appended; mem is appended before alu.
REQ-013 Producer results with Idx == 0 SHALL be discarded without occupying an entry.
REQ-014 ready_out SHALL depend only on the registered occupancy: high iff (DEPTH - count) >= 2; no same-cycle dequeue credit.
REQ-015 A producer asserted while ready_out is low SHALL be ignored, and err_out SHALL be set and held until reset.
REQ-016 Drain: write outputs SHALL be driven combinationally from the head entry; when the queue is empty, writeE_out = 0, writeIdx_out = 0 and writeData_out = 0.
REQ-017 When writeE_out = 1 at a rising edge, the head entry SHALL be removed at that edge; one removal per cycle, in strict FIFO order.
REQ-018 Latency: an entry accepted at edge N into an empty queue SHALL appear on the write port during cycle N+1 and retire at edge N+1.
REQ-019 Simultaneous enqueue (0-2 entries) and dequeue SHALL update count = count + enq - deq; pointers wrap modulo DEPTH.
REQ-020 Hazard lookup considers only valid entries held in the queue, not same-cycle producer inputs; an index of 0 never matches.
REQ-021 When several entries match one index, the youngest entry SHALL be used for matching.
REQ-022 An index matching only the head entry while writeE_out = 1 SHALL be reported as a match; the register file's write-first bypass covers that cycle.

Reset
REQ-023 When rst_in is high at a rising edge: read/write pointers = 0, count = 0, err_out = 0, all entry valids = 0.
REQ-024 While the queue is in reset state, ready_out = 1 and all write, busy and hit outputs = 0.
REQ-025 A reset mid-operation SHALL discard all queued entries without issuing any write, and no enqueue occurs on that edge.

Configuration
REQ-026 Macro WBQ_FORWARD_EN, when defined: on a match, regNHit_out = 1, regNFwdData_out = youngest matching data, and regNBusy_out = 0.
REQ-027 Macro WBQ_FORWARD_EN, when undefined: regNBusy_out = 1 on a match; regNHit_out and regNFwdData_out are tied to 0.

Verification
REQ-028 Empty queue; mem (x5, 0x11) and alu (x6, 0x22) at edge 0 -> cycle 1 write x5 = 0x11; cycle 2 write x6 = 0x22; cycle 3 writeE_out = 0.
REQ-029 Offer alu x0 = 0xFF -> no entry is created, writeE_out stays 0, count stays 0.
REQ-030 DEPTH = 4; enqueue 2 entries for 2 consecutive cycles with no intervening drain -> ready_out = 0 once count >= 3; a further offer sets err_out = 1, and err_out holds after the queue drains.
REQ-031 Queue holds x7 = 0x1, then x7 = 0x2; reg1Idx_in = 7 -> forward build: hit = 1, data = 0x2, busy = 0; non-forward build: busy = 1, hit = 0.
REQ-032 Queue holds 3 entries; assert rst_in for one edge -> next cycle count = 0, writeE_out = 0, ready_out = 1, err_out = 0, and no queued write is ever issued.
REQ-033 Run 20 back-to-back enqueues with continuous drain across pointer wrap -> writes emerge in order, none lost or duplicated.
